ex_muldiv: RTL

//  Iterative RV32M multiply/divide unit in the EX stage, fed by the ID/EX pipeline register.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/ex_muldiv_if.sv | 24 ++
 rtl/ex_muldiv.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit.
// funct3 op codes and FSM state encoding.
package muldiv_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    FAST,
    FIN,
    DONE
  } state_t;
endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX to multiply/divide unit handshake bundle.
// master = pipeline side, slave = ex_muldiv.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, funct3_i, rs1_i, rs2_i, flush_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  valid_i, funct3_i, rs1_i, rs2_i, flush_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide, one bit per cycle.
// Stalls the pipeline until the result is ready.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst_n,
  ex_muldiv_if.slave bus
);
  import muldiv_pkg::*;

  localparam int CNT_W = $clog2(XLEN);
  localparam int W2    = 2 * XLEN;

  function automatic logic [W2-1:0] cneg(
    input logic          n,
    input logic [W2-1:0] v
  );
    return n ? -v : v;
  endfunction

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op;
  logic [XLEN-1:0] ma, mb, res;
  logic [W2-1:0]   acc;
  logic            neg;

  logic [XLEN-1:0] a, b;
  logic [2:0]      f3;
  logic            is_div, sgn_a, sgn_b;
  logic            b_zero, ovf, fast, start;
  logic [XLEN-1:0] fast_val, mag_a, mag_b;

  assign a = bus.rs1_i;
  assign b = bus.rs2_i;
  assign f3 = bus.funct3_i;
  assign is_div = f3[2];
  assign sgn_a = a[XLEN-1] & (is_div ? ~f3[0]
               : (f3 == F3_MULH || f3 == F3_MULHSU));
  assign sgn_b = b[XLEN-1] & (is_div ? ~f3[0]
               : (f3 == F3_MULH));
  assign mag_a = sgn_a ? -a : a;
  assign mag_b = sgn_b ? -b : b;
  assign b_zero = (b == '0);
  assign ovf = is_div & ~f3[0] & (&b)
             & (a == {1'b1, {(XLEN-1){1'b0}}});
  assign fast = is_div & (b_zero | ovf);
  assign start = (state == IDLE) & bus.valid_i & ~bus.flush_i;

  // Overflow quotient equals the dividend, so a covers both cases
  always_comb begin
    fast_val = '0;
    if (f3[1]) fast_val = b_zero ? a : '0;
    else       fast_val = b_zero ? '1 : a;
  end

  logic [XLEN:0]   sum, shl, trial;
  logic [W2-1:0]   mul_nxt, div_nxt, step;
  logic [W2-1:0]   fin_src, fin_fix;
  logic [XLEN-1:0] fin_val;

  // acc = {hi, lo}: product/multiplier or remainder/quotient
  assign sum = {1'b0, acc[W2-1:XLEN]}
             + (acc[0] ? {1'b0, ma} : {(XLEN+1){1'b0}});
  assign mul_nxt = {sum, acc[XLEN-1:1]};
  assign shl = {acc[W2-1:XLEN], acc[XLEN-1]};
  assign trial = shl - {1'b0, mb};
  assign div_nxt = trial[XLEN]
    ? {shl[XLEN-1:0], acc[XLEN-2:0], 1'b0}
    : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign step = op[2] ? div_nxt : mul_nxt;

  always_comb begin
    fin_src = acc;
    if (op[2])
      fin_src = op[1] ? {{XLEN{1'b0}}, acc[W2-1:XLEN]}
                      : {{XLEN{1'b0}}, acc[XLEN-1:0]};
    fin_fix = cneg(neg, fin_src);
    fin_val = (op == F3_MUL || op[2]) ? fin_fix[XLEN-1:0]
                                      : fin_fix[W2-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (start) begin
          op  <= f3;
          ma  <= mag_a;
          mb  <= mag_b;
          cnt <= '0;
          neg <= (is_div & f3[1]) ? sgn_a : (sgn_a ^ sgn_b);
          acc <= fast   ? {{XLEN{1'b0}}, fast_val}
               : is_div ? {{XLEN{1'b0}}, mag_a}
                        : {{XLEN{1'b0}}, mag_b};
        end
        BUSY: begin
          acc <= step;
          cnt <= cnt + 1'b1;
        end
        FAST: if (!bus.flush_i) res <= acc[XLEN-1:0];
        FIN:  if (!bus.flush_i) res <= fin_val;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.stall_o = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        bus.stall_o = 1'b1;
        state_nxt   = fast ? FAST : BUSY;
      end
      BUSY: begin
        bus.stall_o = 1'b1;
        if (cnt == CNT_W'(XLEN-1)) state_nxt = FIN;
      end
      FAST: begin
        bus.stall_o = 1'b1;
        state_nxt   = DONE;
      end
      FIN: begin
        bus.stall_o = 1'b1;
        state_nxt   = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush_i) state_nxt = IDLE;
  end

  assign bus.done_o   = (state == DONE) & ~bus.flush_i;
  assign bus.result_o = res;
endmodule
